dma_dev_port: RTL

- Device-side endpoint that sits directly upstream/downstream of the DMA controller on its device interface.
- Owns a local word buffer and accepts a transfer command from the peripheral logic.
- Issues the DMA request and streams buffer words to the DMA (device->memory write) or captures words from it (memory->device read).
- Reports completion or error back to the peripheral.

---
 rtl/dma_dev_port.sv | 314 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/dma_dev_port.sv
// dma_dev_port
// -----------------------------------------------------------------------------
// Device-side endpoint for the DMA controller's device interface.
//
// This block owns a local word buffer of 2^BUF_DEPTH words. It accepts one
// transfer command from the peripheral logic and raises a one-cycle DMA
// request. It then does one of two things:
//   - device->memory (cmd_rd_wr = 0): streams buffer words to the DMA.
//   - memory->device (cmd_rd_wr = 1): captures words from the DMA.
// It reports completion (done) or failure (error) back to the peripheral.
//
// Optional build macro: DMA_DEV_TIMEOUT_EN
//   When defined, a watchdog runs in REQ/XFER and adds the 'timeout' output.
//   It aborts a transfer that makes no progress for TIMEOUT_CYCLES cycles.
//   When undefined, the FSM waits indefinitely for end_flag / error_flag.
//
// Ports
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   cmd_*              transfer command from the peripheral (cmd_start pulse)
//   stall              peripheral throttle, drives dev_ack low one cycle later
//   buf_addr/wdata/we  host buffer port (writes ignored while busy)
//   buf_rdata          host read data, registered, 1-cycle latency
//   busy/done/error    status to the peripheral (error is sticky)
//   timeout            watchdog expiry, sticky (only with DMA_DEV_TIMEOUT_EN)
//   xfer_count         words moved in the current or last transfer, saturating
//   num_words, start_addr, rd_wr, rqst, dev_ack, dev_in
//                      command and handshake outputs to the DMA controller
//   dma_ack, dev_out, end_flag, error_flag
//                      handshake inputs from the DMA controller
// -----------------------------------------------------------------------------
module dma_dev_port #(
  parameter int ADD_LEN        = 16,
  parameter int DATA_LEN       = 16,
  parameter int BUF_DEPTH      = 5,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                reset,
  // command from the peripheral
  input  logic                cmd_start,
  input  logic                cmd_rd_wr,
  input  logic [ADD_LEN:0]    cmd_addr,
  input  logic [ADD_LEN-1:0]  cmd_words,
  input  logic                stall,
  // host buffer port
  input  logic [BUF_DEPTH-1:0] buf_addr,
  input  logic [DATA_LEN-1:0] buf_wdata,
  input  logic                buf_we,
  output logic [DATA_LEN-1:0] buf_rdata,
  // status to the peripheral
  output logic                busy,
  output logic                done,
  output logic                error,
`ifdef DMA_DEV_TIMEOUT_EN
  output logic                timeout,
`endif
  output logic [ADD_LEN-1:0]  xfer_count,
  // DMA controller interface
  output logic [ADD_LEN-1:0]  num_words,
  output logic [ADD_LEN:0]    start_addr,
  output logic                rd_wr,
  output logic                rqst,
  output logic                dev_ack,
  output logic [DATA_LEN-1:0] dev_in,
  input  logic                dma_ack,
  input  logic [DATA_LEN-1:0] dev_out,
  input  logic                end_flag,
  input  logic                error_flag
);

  localparam int DEPTH = 32'sd1 <<< BUF_DEPTH;
  localparam logic [BUF_DEPTH-1:0] PTR_ONE = {{(BUF_DEPTH-1){1'b0}}, 1'b1};
  localparam logic [ADD_LEN-1:0]   CNT_ONE = {{(ADD_LEN-1){1'b0}}, 1'b1};
  localparam logic [ADD_LEN-1:0]   CNT_MAX = {ADD_LEN{1'b1}};

  // Elaboration-time sanity check on the configuration.
  if (TIMEOUT_CYCLES < 32'sd1 || BUF_DEPTH < 32'sd1) begin : g_param_check
    $error("dma_dev_port: TIMEOUT_CYCLES and BUF_DEPTH must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_XFER = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [BUF_DEPTH-1:0] ptr_q, ptr_d;
  logic [ADD_LEN-1:0]   xfer_count_q, xfer_count_d;
  logic [ADD_LEN-1:0]   num_words_q, num_words_d;
  logic [ADD_LEN:0]     start_addr_q, start_addr_d;
  logic                 rd_wr_q, rd_wr_d;
  logic                 rqst_q, rqst_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic                 dev_ack_q, dev_ack_d;
  logic [DATA_LEN-1:0]  buf_rdata_q;

  logic [DATA_LEN-1:0]  mem_q [DEPTH];
  logic                 mem_we_s;
  logic [BUF_DEPTH-1:0] mem_waddr_s;
  logic [DATA_LEN-1:0]  mem_wdata_s;
  logic [DATA_LEN-1:0]  dev_in_s;

`ifdef DMA_DEV_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 32'sd1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 32'sd1);
  localparam logic [WD_W-1:0] WD_ONE  = {{(WD_W-1){1'b0}}, 1'b1};
  logic [WD_W-1:0]      wd_q, wd_d;
  logic                 timeout_q, timeout_d;
`endif

  // Next-state and next-output computation for the transfer FSM.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    xfer_count_d = xfer_count_q;
    num_words_d  = num_words_q;
    start_addr_d = start_addr_q;
    rd_wr_d      = rd_wr_q;
    error_d      = error_q;
    rqst_d       = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    dev_ack_d    = 1'b0;
`ifdef DMA_DEV_TIMEOUT_EN
    wd_d         = wd_q;
    timeout_d    = timeout_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (cmd_start) begin
          num_words_d  = cmd_words;
          start_addr_d = cmd_addr;
          rd_wr_d      = cmd_rd_wr;
          xfer_count_d = '0;
          ptr_d        = '0;
          error_d      = 1'b0;
`ifdef DMA_DEV_TIMEOUT_EN
          timeout_d    = 1'b0;
          wd_d         = '0;
`endif
          rqst_d       = 1'b1;
          busy_d       = 1'b1;
          state_d      = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        busy_d    = 1'b1;
        dev_ack_d = ~stall;
        state_d   = S_XFER;
      end
      S_XFER: begin
        // A strobe is always consumed, even when the transfer ends in the
        // same cycle, so the last word is never lost.
        if (dma_ack) begin
          ptr_d = ptr_q + PTR_ONE;
          if (xfer_count_q != CNT_MAX) begin
            xfer_count_d = xfer_count_q + CNT_ONE;
          end else begin
            xfer_count_d = xfer_count_q;
          end
        end else begin
          ptr_d = ptr_q;
        end
        // A bus error takes priority over a normal end.
        if (error_flag) begin
          error_d = 1'b1;
          done_d  = 1'b1;
          state_d = S_ERR;
        end else if (end_flag) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          busy_d    = 1'b1;
          dev_ack_d = ~stall;
          state_d   = S_XFER;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef DMA_DEV_TIMEOUT_EN
    // The watchdog counts only while waiting on the DMA. Any strobe or a
    // peripheral stall counts as progress and clears it.
    if (state_q == S_REQ || state_q == S_XFER) begin
      if (dma_ack || stall) begin
        wd_d = '0;
      end else if (wd_q == WD_LAST && !end_flag && !error_flag) begin
        wd_d      = '0;
        error_d   = 1'b1;
        timeout_d = 1'b1;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        rqst_d    = 1'b0;
        dev_ack_d = 1'b0;
        state_d   = S_ERR;
      end else begin
        wd_d = wd_q + WD_ONE;
      end
    end else begin
      wd_d = '0;
    end
`endif
  end

  // Transfer FSM state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      xfer_count_q <= '0;
      num_words_q  <= '0;
      start_addr_q <= '0;
      rd_wr_q      <= 1'b0;
      rqst_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      dev_ack_q    <= 1'b0;
`ifdef DMA_DEV_TIMEOUT_EN
      wd_q         <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      xfer_count_q <= xfer_count_d;
      num_words_q  <= num_words_d;
      start_addr_q <= start_addr_d;
      rd_wr_q      <= rd_wr_d;
      rqst_q       <= rqst_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      dev_ack_q    <= dev_ack_d;
`ifdef DMA_DEV_TIMEOUT_EN
      wd_q         <= wd_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  // Buffer write-port arbitration: DMA capture in a read transfer, otherwise the host while idle.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = buf_addr;
    mem_wdata_s = buf_wdata;
    if (state_q == S_XFER && rd_wr_q && dma_ack) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = ptr_q;
      mem_wdata_s = dev_out;
    end else if (buf_we && !busy_q) begin
      mem_we_s    = 1'b1;
    end else begin
      mem_we_s    = 1'b0;
    end
  end

  // Buffer storage; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Registered host read port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_rdata_q <= '0;
    end else begin
      buf_rdata_q <= mem_q[buf_addr];
    end
  end

  // Write-direction data: presented only while streaming, so the bus idles at zero.
  always_comb begin
    if (state_q == S_XFER && !rd_wr_q) begin
      dev_in_s = mem_q[ptr_q];
    end else begin
      dev_in_s = '0;
    end
  end

  assign buf_rdata  = buf_rdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign xfer_count = xfer_count_q;
  assign num_words  = num_words_q;
  assign start_addr = start_addr_q;
  assign rd_wr      = rd_wr_q;
  assign rqst       = rqst_q;
  assign dev_ack    = dev_ack_q;
  assign dev_in     = dev_in_s;
`ifdef DMA_DEV_TIMEOUT_EN
  assign timeout    = timeout_q;
`endif

endmodule
